cg_tlb_fully_associative: RTL and testbench

Fully-associative translation lookaside buffer for Sv39-style virtual addresses with 4 KiB pages. It sits between the core's address-generation stage and the page-table walker (PTW). Each cycle it looks up one virtual address, tagged by ASID, and returns the physical address one cycle later or flags a miss. The PTW refills entries through a fill port, and software or the core invalidates entries through a flush input.

---
 rtl/cg_tlb_fully_associative_pkg.sv | 32 +++
 rtl/cg_tlb_fully_associative_if.sv | 41 ++++
 rtl/cg_tlb_fully_associative_match.sv | 29 ++
 rtl/cg_tlb_fully_associative.sv | 122 ++++++++++++
 tb/tb_cg_tlb_fully_associative.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/cg_tlb_fully_associative_pkg.sv
// Shared types and helpers for the fully-associative Sv39 TLB.
// Entry field widths follow the default address widths of the block.
package cg_tlb_pkg;

    localparam int PAGE_OFFSET_WIDTH = 12;
    localparam int TLB_VADDR_WIDTH   = 39;
    localparam int TLB_PADDR_WIDTH   = 56;
    localparam int TLB_ASID_WIDTH    = 16;
    localparam int VPN_WIDTH         = TLB_VADDR_WIDTH - PAGE_OFFSET_WIDTH;
    localparam int PPN_WIDTH         = TLB_PADDR_WIDTH - PAGE_OFFSET_WIDTH;

    typedef struct packed {
        logic                      valid;
        logic                      is_global;
        logic [TLB_ASID_WIDTH-1:0] asid;
        logic [VPN_WIDTH-1:0]      vpn;
        logic [PPN_WIDTH-1:0]      ppn;
    } tlb_entry_t;

    // An entry matches when it is valid, the VPN is equal and the ASID agrees.
    // any_asid lets the fill path treat an incoming global entry as matching
    // every ASID, so a global refill replaces an existing per-ASID copy.
    function automatic logic tlb_entry_hit(
        input tlb_entry_t                e,
        input logic [VPN_WIDTH-1:0]      vpn,
        input logic [TLB_ASID_WIDTH-1:0] asid,
        input logic                      any_asid
    );
        return e.valid && (e.vpn == vpn) && (e.is_global || any_asid || (e.asid == asid));
    endfunction

endpackage

// File: rtl/cg_tlb_fully_associative_if.sv
// Lookup, fill and flush signals between the core/PTW and the TLB.
// Handshake: a lookup is accepted every cycle i_vaddr_valid is high and is
// answered exactly one cycle later by either o_paddr_valid or o_tlb_miss;
// the TLB never stalls, so there is no ready signal. Fills and flushes are
// likewise single-cycle strobes that are always accepted.
interface cg_tlb_fully_associative_if
    import cg_tlb_pkg::*;
#(
    parameter int VADDR_WIDTH = TLB_VADDR_WIDTH,
    parameter int PADDR_WIDTH = TLB_PADDR_WIDTH,
    parameter int ASID_WIDTH  = TLB_ASID_WIDTH
);

    logic                    i_vaddr_valid;
    logic [VADDR_WIDTH-1:0]  i_vaddr;
    logic [ASID_WIDTH-1:0]   i_asid;
    logic                    o_paddr_valid;
    logic [PADDR_WIDTH-1:0]  o_paddr;
    logic                    o_tlb_miss;
    logic                    i_fill_valid;
    logic [VADDR_WIDTH-13:0] i_fill_vpn;
    logic [PADDR_WIDTH-13:0] i_fill_ppn;
    logic [ASID_WIDTH-1:0]   i_fill_asid;
    logic                    i_fill_global;
    logic                    i_flush;

    modport master (
        output i_vaddr_valid, i_vaddr, i_asid,
        output i_fill_valid, i_fill_vpn, i_fill_ppn, i_fill_asid, i_fill_global,
        output i_flush,
        input  o_paddr_valid, o_paddr, o_tlb_miss
    );

    modport slave (
        input  i_vaddr_valid, i_vaddr, i_asid,
        input  i_fill_valid, i_fill_vpn, i_fill_ppn, i_fill_asid, i_fill_global,
        input  i_flush,
        output o_paddr_valid, o_paddr, o_tlb_miss
    );

endinterface

// File: rtl/cg_tlb_fully_associative_match.sv
// Combinational compare of every TLB entry against one VPN/ASID pair.
// Produces a hit vector and the OR of the PPNs of hitting entries, which is
// the single hitting PPN as long as at most one entry matches.
module cg_tlb_match
    import cg_tlb_pkg::*;
#(
    parameter int NUM_ENTRIES = 8
) (
    input  tlb_entry_t                entries [NUM_ENTRIES],
    input  logic [VPN_WIDTH-1:0]      vpn,
    input  logic [TLB_ASID_WIDTH-1:0] asid,
    input  logic                      any_asid,
    output logic [NUM_ENTRIES-1:0]    hit_vec,
    output logic [PPN_WIDTH-1:0]      hit_ppn
);

    // Compare all entries in parallel and merge the matching PPN.
    always_comb begin
        hit_vec = '0;
        hit_ppn = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            hit_vec[i] = tlb_entry_hit(entries[i], vpn, asid, any_asid);
            if (hit_vec[i]) begin
                hit_ppn = hit_ppn | entries[i].ppn;
            end
        end
    end

endmodule

// File: rtl/cg_tlb_fully_associative.sv
// Fully-associative TLB: one lookup per cycle with a registered one-cycle
// result, one PTW fill per cycle, and a whole-array flush.
module cg_tlb_fully_associative
    import cg_tlb_pkg::*;
#(
    parameter int VADDR_WIDTH = TLB_VADDR_WIDTH,
    parameter int PADDR_WIDTH = TLB_PADDR_WIDTH,
    parameter int ASID_WIDTH  = TLB_ASID_WIDTH,
    parameter int NUM_ENTRIES = 8
) (
    input logic                        i_clk,
    input logic                        i_rst,
    cg_tlb_fully_associative_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);

    tlb_entry_t                entries [NUM_ENTRIES];
    logic [IDX_W-1:0]          victim_ptr;

    logic [VPN_WIDTH-1:0]      look_vpn;
    logic [PAGE_OFFSET_WIDTH-1:0] look_offset;
    logic [NUM_ENTRIES-1:0]    look_hit_vec;
    logic [PPN_WIDTH-1:0]      look_ppn;
    logic                      look_hit;

    logic [NUM_ENTRIES-1:0]    dup_vec;
    logic [PPN_WIDTH-1:0]      dup_ppn_unused;
    logic [IDX_W-1:0]          fill_idx;
    logic                      fill_replace;

    logic                      paddr_valid_q;
    logic [PADDR_WIDTH-1:0]    paddr_q;
    logic                      tlb_miss_q;

    assign look_vpn    = bus.i_vaddr[VADDR_WIDTH-1:PAGE_OFFSET_WIDTH];
    assign look_offset = bus.i_vaddr[PAGE_OFFSET_WIDTH-1:0];
    assign look_hit    = |look_hit_vec;

    cg_tlb_match #(.NUM_ENTRIES(NUM_ENTRIES)) u_look_match (
        .entries  (entries),
        .vpn      (look_vpn),
        .asid     (bus.i_asid),
        .any_asid (1'b0),
        .hit_vec  (look_hit_vec),
        .hit_ppn  (look_ppn)
    );

    // The fill path reuses the matcher to find an existing copy of the
    // incoming translation so a refill never creates a second hitting entry.
    cg_tlb_match #(.NUM_ENTRIES(NUM_ENTRIES)) u_fill_match (
        .entries  (entries),
        .vpn      (bus.i_fill_vpn),
        .asid     (bus.i_fill_asid),
        .any_asid (bus.i_fill_global),
        .hit_vec  (dup_vec),
        .hit_ppn  (dup_ppn_unused)
    );

    // Pick the fill slot: existing copy, else lowest invalid, else victim.
    always_comb begin
        logic found;
        found        = 1'b0;
        fill_idx     = '0;
        fill_replace = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!found && dup_vec[i]) begin
                fill_idx = i[IDX_W-1:0];
                found    = 1'b1;
            end
        end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!found && !entries[i].valid) begin
                fill_idx = i[IDX_W-1:0];
                found    = 1'b1;
            end
        end
        if (!found) begin
            fill_idx     = victim_ptr;
            fill_replace = 1'b1;
        end
    end

    // Register lookup results and update the entry array; flush beats fill.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entries[i] <= '0;
            end
            victim_ptr    <= '0;
            paddr_valid_q <= 1'b0;
            paddr_q       <= '0;
            tlb_miss_q    <= 1'b0;
        end else begin
            paddr_valid_q <= bus.i_vaddr_valid && look_hit;
            tlb_miss_q    <= bus.i_vaddr_valid && !look_hit;
            paddr_q       <= (bus.i_vaddr_valid && look_hit) ? {look_ppn, look_offset} : '0;
            if (bus.i_flush) begin
                for (int i = 0; i < NUM_ENTRIES; i++) begin
                    entries[i].valid <= 1'b0;
                end
                victim_ptr <= '0;
            end else if (bus.i_fill_valid) begin
                entries[fill_idx] <= '{
                    valid:     1'b1,
                    is_global: bus.i_fill_global,
                    asid:      bus.i_fill_asid,
                    vpn:       bus.i_fill_vpn,
                    ppn:       bus.i_fill_ppn
                };
                if (fill_replace) begin
                    victim_ptr <= victim_ptr + IDX_W'(1);
                end
            end
        end
    end

    assign bus.o_paddr_valid = paddr_valid_q;
    assign bus.o_paddr       = paddr_q;
    assign bus.o_tlb_miss    = tlb_miss_q;

endmodule

// File: tb/tb_cg_tlb_fully_associative.sv
// Directed scoreboard bench for the fully-associative TLB.
module tb_cg_tlb_fully_associative;

    typedef struct {
        string       name;
        logic        pv;
        logic [55:0] pa;
        logic        miss;
    } exp_t;

    logic clk;
    logic rst;
    exp_t exp_q[$];
    int   n_cmp;
    int   n_fail;

    cg_tlb_fully_associative_if bus ();

    cg_tlb_fully_associative dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Clock and reset defaults.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One cycle of stimulus; the expected response for the following cycle
    // is queued right after the capturing edge.
    task automatic drive(input string name, input logic r,
                         input logic lv, input logic [38:0] va, input logic [15:0] as,
                         input logic fv, input logic [26:0] fvpn, input logic [43:0] fppn,
                         input logic [15:0] fas, input logic fg, input logic fl,
                         input logic ev, input logic [55:0] ep, input logic em);
        exp_t e;
        rst                = r;
        bus.i_vaddr_valid  = lv;
        bus.i_vaddr        = va;
        bus.i_asid         = as;
        bus.i_fill_valid   = fv;
        bus.i_fill_vpn     = fvpn;
        bus.i_fill_ppn     = fppn;
        bus.i_fill_asid    = fas;
        bus.i_fill_global  = fg;
        bus.i_flush        = fl;
        @(posedge clk);
        e.name = name;
        e.pv   = ev;
        e.pa   = ep;
        e.miss = em;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic look_hit(input string name, input logic [38:0] va, input logic [15:0] as,
                            input logic [55:0] ep);
        drive(name, 1'b0, 1'b1, va, as, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, ep, 1'b0);
    endtask

    task automatic look_miss(input string name, input logic [38:0] va, input logic [15:0] as);
        drive(name, 1'b0, 1'b1, va, as, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic fill(input string name, input logic [26:0] vpn, input logic [43:0] ppn,
                        input logic [15:0] as, input logic g);
        drive(name, 1'b0, 1'b0, '0, '0, 1'b1, vpn, ppn, as, g, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic idle(input string name);
        drive(name, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    // Monitor: pop and compare one expected response per cycle, away from the edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.o_paddr_valid !== e.pv || bus.o_paddr !== e.pa || bus.o_tlb_miss !== e.miss) begin
                n_fail++;
                $display("FAIL %s: got valid=%0b paddr=%h miss=%0b, want valid=%0b paddr=%h miss=%0b",
                         e.name, bus.o_paddr_valid, bus.o_paddr, bus.o_tlb_miss, e.pv, e.pa, e.miss);
            end
        end
    end

    // Directed sequence.
    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        bus.i_vaddr_valid = 1'b0;
        bus.i_vaddr       = '0;
        bus.i_asid        = '0;
        bus.i_fill_valid  = 1'b0;
        bus.i_fill_vpn    = '0;
        bus.i_fill_ppn    = '0;
        bus.i_fill_asid   = '0;
        bus.i_fill_global = 1'b0;
        bus.i_flush       = 1'b0;

        // Reset state.
        drive("reset0", 1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        drive("reset1", 1'b1, 1'b1, 39'h7F_FFFF_FFFF, 16'd3, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);

        // Cold lookup held for 10 cycles: miss every cycle.
        for (int i = 0; i < 10; i++) look_miss("cold_miss", 39'h7F_FFFF_FFFF, 16'd3);
        idle("idle_after_cold");

        // Fill then hit.
        fill("fill_asid5", 27'h7FF_FFFF, 44'hABCDE, 16'd5, 1'b0);
        look_hit("hit_asid5", 39'h7F_FFFF_F123, 16'd5, 56'hABCDE123);

        // ASID mismatch misses; a global refill of the same VPN replaces the entry.
        look_miss("miss_asid6", 39'h7F_FFFF_F123, 16'd6);
        fill("fill_global", 27'h7FF_FFFF, 44'h13579, 16'd9, 1'b1);
        look_hit("global_asid6", 39'h7F_FFFF_F123, 16'd6, 56'h13579123);
        look_hit("global_asid5_nodup", 39'h7F_FFFF_F123, 16'd5, 56'h13579123);
        idle("idle_novalid");

        // Flush ordering: the lookup in the flush cycle still hits.
        drive("flush_cycle_hit", 1'b0, 1'b1, 39'h7F_FFFF_F123, 16'd6, 1'b0, '0, '0, '0, 1'b0, 1'b1,
              1'b1, 56'h13579123, 1'b0);
        look_miss("after_flush_miss", 39'h7F_FFFF_F123, 16'd6);
        drive("flush_plus_fill", 1'b0, 1'b0, '0, '0, 1'b1, 27'h100, 44'h777, 16'd1, 1'b0, 1'b1,
              1'b0, '0, 1'b0);
        look_miss("dropped_fill_miss", 39'h00_0010_0000, 16'd1);

        // Replacement: eight fills into an empty array, then a ninth evicts entry 0.
        for (int i = 0; i < 8; i++) fill("fill_rr", 27'h10 + 27'(i), 44'h100 + 44'(i), 16'd1, 1'b0);
        drive("fill9_same_cycle_miss", 1'b0, 1'b1, {27'h18, 12'hABC}, 16'd1,
              1'b1, 27'h18, 44'h200, 16'd1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        look_hit("fill9_next_cycle_hit", {27'h18, 12'hABC}, 16'd1, {44'h200, 12'hABC});
        look_miss("evicted_entry0", {27'h10, 12'hABC}, 16'd1);
        for (int i = 1; i < 8; i++)
            look_hit("survivor_hit", {27'h10 + 27'(i), 12'hABC}, 16'd1, {44'h100 + 44'(i), 12'hABC});

        // Reset mid-stream.
        for (int i = 0; i < 3; i++) look_hit("stream_hit", {27'h11, 12'h045}, 16'd1, {44'h101, 12'h045});
        drive("reset_mid", 1'b1, 1'b1, {27'h11, 12'h045}, 16'd1, 1'b0, '0, '0, '0, 1'b0, 1'b0,
              1'b0, '0, 1'b0);
        look_miss("post_reset_miss", {27'h11, 12'h045}, 16'd1);
        idle("final_idle");

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: got %0d pending responses, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
